// File: rtl/hls_deadlock_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | hls_deadlock_pkg                                                      |
// | Shared types and helpers for the HLS deadlock monitor.                |
// | Revision: 1.0                                                         |
// +-----------------------------------------------------------------------+
package hls_deadlock_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SUSPECT = 2'd1,
    BLOCKED = 2'd2
  } state_e;

  // Ceiling log2 with a floor of 1 so that single-value ranges still get a bit.
  function automatic int clog2(input int value);
    int r;
    int v;
    r = 0;
    v = value - 1;
    while (v > 0) begin
      r++;
      v = v >> 1;
    end
    return (r < 1) ? 1 : r;
  endfunction

  function automatic int sub_width(input int n_sub);
    return (n_sub > 0) ? n_sub : 1;
  endfunction

  // Source index that reports a sub-instance cause sits just past the stream channels.
  function automatic int sub_cause(input int n_axis);
    return n_axis;
  endfunction

endpackage : hls_deadlock_pkg
`default_nettype wire

// File: rtl/hls_deadlock_persist_cnt.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | hls_deadlock_persist_cnt                                              |
// | Saturating persistence counter; hit flags the edge that reaches THRESH.|
// | Revision: 1.0                                                         |
// +-----------------------------------------------------------------------+
module hls_deadlock_persist_cnt
  import hls_deadlock_pkg::*;
#(
  parameter int THRESH = 16,
  parameter int CNT_W  = clog2(THRESH + 1)
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  input  logic inc,
  output logic hit
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(THRESH);
  localparam logic [CNT_W:0]   HIT_VAL = (CNT_W + 1)'(THRESH);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear || !inc) begin
      cnt_d = '0;
    end else if (cnt_q != CNT_MAX) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // hit is the cycle whose increment completes the THRESH-long run.
  assign hit = inc && (({1'b0, cnt_q} + 1'b1) == HIT_VAL);

endmodule : hls_deadlock_persist_cnt
`default_nettype wire

// File: rtl/hls_deadlock_multi_monitor.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | hls_deadlock_multi_monitor                                            |
// | Multi-source deadlock monitor with persistence filter and cause capture.|
// | Revision: 1.0                                                         |
// +-----------------------------------------------------------------------+
module hls_deadlock_multi_monitor
  import hls_deadlock_pkg::*;
#(
  parameter int N_AXIS = 4,
  parameter int N_SUB  = 2,
  parameter int THRESH = 16,
  parameter int STICKY = 0,
  parameter int CYC_W  = 16,
  parameter int IDX_W  = clog2(N_AXIS + 1)
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic [N_AXIS-1:0]           axis_block_sigs,
  input  logic [sub_width(N_SUB)-1:0] inst_idle_sigs,
  input  logic [sub_width(N_SUB)-1:0] inst_block_sigs,
  input  logic                        clear,
  output logic                        block,
  output logic                        src_valid,
  output logic [IDX_W-1:0]            src_idx,
  output logic [CYC_W-1:0]            blocked_cycles
);

  logic axis_any;
  logic sub_all;
  logic seq_block;
  logic hit;

  assign axis_any = |axis_block_sigs;

  generate
    if (N_SUB > 0) begin : g_sub
      // All-idle sub-instances are finished work, not a deadlock.
      assign sub_all = (&(inst_block_sigs | inst_idle_sigs)) & (|inst_block_sigs);
    end else begin : g_no_sub
      assign sub_all = 1'b0;
    end
  endgenerate

  assign seq_block = axis_any | sub_all;

  hls_deadlock_persist_cnt #(
    .THRESH (THRESH)
  ) u_persist (
    .clock (clock),
    .reset (reset),
    .clear (clear),
    .inc   (seq_block),
    .hit   (hit)
  );

  logic [IDX_W-1:0] first_src;

  always_comb begin
    first_src = IDX_W'(sub_cause(N_AXIS));
    for (int i = N_AXIS - 1; i >= 0; i--) begin
      if (axis_block_sigs[i]) begin
        first_src = IDX_W'(i);
      end
    end
  end

  state_e           state_q,     state_d;
  logic             block_q,     block_d;
  logic             src_valid_q, src_valid_d;
  logic [IDX_W-1:0] src_idx_q,   src_idx_d;
  logic [CYC_W-1:0] blocked_q,   blocked_d;

  always_comb begin
    state_d     = state_q;
    src_valid_d = src_valid_q;
    src_idx_d   = src_idx_q;
    blocked_d   = blocked_q;
    if (clear) begin
      state_d     = IDLE;
      src_valid_d = 1'b0;
      src_idx_d   = '0;
      blocked_d   = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (seq_block) begin
            src_valid_d = 1'b1;
            src_idx_d   = first_src;
            if (THRESH == 1) begin
              state_d   = BLOCKED;
              blocked_d = CYC_W'(1);
            end else begin
              state_d = SUSPECT;
            end
          end
        end
        SUSPECT: begin
          if (!seq_block) begin
            state_d     = IDLE;
            src_valid_d = 1'b0;
            src_idx_d   = '0;
          end else if (hit) begin
            state_d   = BLOCKED;
            blocked_d = CYC_W'(1);
          end
        end
        BLOCKED: begin
          if (!seq_block && (STICKY == 0)) begin
            state_d = IDLE;
          end else if (blocked_q != {CYC_W{1'b1}}) begin
            blocked_d = blocked_q + 1'b1;
          end
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
    block_d = (state_d == BLOCKED);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= IDLE;
      block_q     <= 1'b0;
      src_valid_q <= 1'b0;
      src_idx_q   <= '0;
      blocked_q   <= '0;
    end else begin
      state_q     <= state_d;
      block_q     <= block_d;
      src_valid_q <= src_valid_d;
      src_idx_q   <= src_idx_d;
      blocked_q   <= blocked_d;
    end
  end

  assign block          = block_q;
  assign src_valid      = src_valid_q;
  assign src_idx        = src_idx_q;
  assign blocked_cycles = blocked_q;

endmodule : hls_deadlock_multi_monitor
`default_nettype wire

// File: tb/tb_hls_deadlock_multi_monitor.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | tb_hls_deadlock_multi_monitor                                         |
// | Directed bench over three monitor configurations sharing one stimulus.|
// | Revision: 1.0                                                         |
// +-----------------------------------------------------------------------+
module tb_hls_deadlock_multi_monitor;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] axis  = '0;
  logic [1:0] idle  = '0;
  logic [1:0] blk   = '0;
  logic       clear = 1'b0;

  int vectors    = 0;
  int miscompares = 0;

  always #5 clock = ~clock;

  // u_t1: legacy latency; u_t16: default thresholds; u_st: sticky, narrow counter.
  logic        t1_block, t1_valid;
  logic [2:0]  t1_idx;
  logic [15:0] t1_cyc;
  logic        t16_block, t16_valid;
  logic [2:0]  t16_idx;
  logic [15:0] t16_cyc;
  logic        st_block, st_valid;
  logic [2:0]  st_idx;
  logic [3:0]  st_cyc;

  wire [20:0] t1_obs  = {t1_block, t1_valid, t1_idx, t1_cyc};
  wire [20:0] t16_obs = {t16_block, t16_valid, t16_idx, t16_cyc};
  wire [8:0]  st_obs  = {st_block, st_valid, st_idx, st_cyc};

  hls_deadlock_multi_monitor #(.THRESH(1), .STICKY(0), .CYC_W(16)) u_t1 (
    .clock(clock), .reset(reset), .axis_block_sigs(axis), .inst_idle_sigs(idle),
    .inst_block_sigs(blk), .clear(clear), .block(t1_block), .src_valid(t1_valid),
    .src_idx(t1_idx), .blocked_cycles(t1_cyc));

  hls_deadlock_multi_monitor #(.THRESH(16), .STICKY(0), .CYC_W(16)) u_t16 (
    .clock(clock), .reset(reset), .axis_block_sigs(axis), .inst_idle_sigs(idle),
    .inst_block_sigs(blk), .clear(clear), .block(t16_block), .src_valid(t16_valid),
    .src_idx(t16_idx), .blocked_cycles(t16_cyc));

  hls_deadlock_multi_monitor #(.THRESH(4), .STICKY(1), .CYC_W(4)) u_st (
    .clock(clock), .reset(reset), .axis_block_sigs(axis), .inst_idle_sigs(idle),
    .inst_block_sigs(blk), .clear(clear), .block(st_block), .src_valid(st_valid),
    .src_idx(st_idx), .blocked_cycles(st_cyc));

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic do_reset();
    axis  = '0;
    idle  = '0;
    blk   = '0;
    clear = 1'b0;
    reset = 1'b1;
    tick(2);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    axis  = 4'hF;
    blk   = 2'b11;
    reset = 1'b1;
    tick(2);
    vectors++;
    if (t1_obs !== 21'h0) begin
      miscompares++;
      $display("FAIL reset_t1 got %h want %h", t1_obs, 21'h0);
    end
    vectors++;
    if (t16_obs !== 21'h0) begin
      miscompares++;
      $display("FAIL reset_t16 got %h want %h", t16_obs, 21'h0);
    end
    vectors++;
    if (st_obs !== 9'h0) begin
      miscompares++;
      $display("FAIL reset_st got %h want %h", st_obs, 9'h0);
    end
    do_reset();
  endtask

  task automatic test_legacy();
    do_reset();
    tick(4);
    axis = 4'b0001;
    for (int i = 0; i < 3; i++) begin
      tick(1);
      vectors++;
      if (t1_obs !== {1'b1, 1'b1, 3'd0, 16'(i + 1)}) begin
        miscompares++;
        $display("FAIL legacy_hold%0d got %h want %h", i, t1_obs, {1'b1, 1'b1, 3'd0, 16'(i + 1)});
      end
    end
    axis = 4'b0000;
    tick(1);
    vectors++;
    if (t1_obs !== {1'b0, 1'b1, 3'd0, 16'd3}) begin
      miscompares++;
      $display("FAIL legacy_release got %h want %h", t1_obs, {1'b0, 1'b1, 3'd0, 16'd3});
    end
  endtask

  task automatic test_priority();
    do_reset();
    axis = 4'b1010;
    tick(1);
    vectors++;
    if (t1_obs !== {1'b1, 1'b1, 3'd1, 16'd1}) begin
      miscompares++;
      $display("FAIL lowest_index got %h want %h", t1_obs, {1'b1, 1'b1, 3'd1, 16'd1});
    end
    axis = 4'b0100;
    tick(1);
    vectors++;
    if (t1_obs !== {1'b1, 1'b1, 3'd1, 16'd2}) begin
      miscompares++;
      $display("FAIL src_frozen got %h want %h", t1_obs, {1'b1, 1'b1, 3'd1, 16'd2});
    end
  endtask

  task automatic test_persist();
    logic early;
    do_reset();
    axis  = 4'b0100;
    early = 1'b0;
    for (int i = 0; i < 15; i++) begin
      tick(1);
      early = early | t16_block;
    end
    vectors++;
    if (early !== 1'b0) begin
      miscompares++;
      $display("FAIL persist_short_burst got %b want %b", early, 1'b0);
    end
    axis = 4'b0000;
    tick(1);
    vectors++;
    if (t16_obs !== 21'h0) begin
      miscompares++;
      $display("FAIL persist_gap got %h want %h", t16_obs, 21'h0);
    end
    axis = 4'b0100;
    for (int i = 0; i < 20; i++) begin
      tick(1);
      vectors++;
      if (t16_block !== (i >= 15)) begin
        miscompares++;
        $display("FAIL persist_burst_c%0d got %b want %b", i + 1, t16_block, (i >= 15));
      end
    end
    axis = 4'b0000;
    tick(1);
    vectors++;
    if (t16_obs !== {1'b0, 1'b1, 3'd2, 16'd5}) begin
      miscompares++;
      $display("FAIL persist_end got %h want %h", t16_obs, {1'b0, 1'b1, 3'd2, 16'd5});
    end
  endtask

  task automatic test_sub_path();
    do_reset();
    idle = 2'b01;
    blk  = 2'b10;
    tick(16);
    vectors++;
    if (t16_obs !== {1'b1, 1'b1, 3'd4, 16'd1}) begin
      miscompares++;
      $display("FAIL sub_cause got %h want %h", t16_obs, {1'b1, 1'b1, 3'd4, 16'd1});
    end
    do_reset();
    idle = 2'b11;
    blk  = 2'b00;
    tick(20);
    vectors++;
    if ({t1_block, t16_block, t16_valid} !== 3'b000) begin
      miscompares++;
      $display("FAIL sub_all_idle got %b want %b", {t1_block, t16_block, t16_valid}, 3'b000);
    end
  endtask

  task automatic test_sticky();
    do_reset();
    axis = 4'b0001;
    tick(3);
    vectors++;
    if (st_block !== 1'b0) begin
      miscompares++;
      $display("FAIL sticky_pre got %b want %b", st_block, 1'b0);
    end
    tick(1);
    axis = 4'b0000;
    tick(3);
    vectors++;
    if (st_obs !== {1'b1, 1'b1, 3'd0, 4'd4}) begin
      miscompares++;
      $display("FAIL sticky_hold got %h want %h", st_obs, {1'b1, 1'b1, 3'd0, 4'd4});
    end
    clear = 1'b1;
    tick(1);
    clear = 1'b0;
    vectors++;
    if (st_obs !== 9'h0) begin
      miscompares++;
      $display("FAIL sticky_clear got %h want %h", st_obs, 9'h0);
    end
  endtask

  task automatic test_saturation();
    do_reset();
    axis = 4'b0001;
    tick(40);
    vectors++;
    if (st_obs !== {1'b1, 1'b1, 3'd0, 4'd15}) begin
      miscompares++;
      $display("FAIL sat_narrow got %h want %h", st_obs, {1'b1, 1'b1, 3'd0, 4'd15});
    end
    vectors++;
    if (t16_cyc !== 16'd25) begin
      miscompares++;
      $display("FAIL sat_wide_count got %0d want %0d", t16_cyc, 25);
    end
  endtask

  task automatic test_reset_mid();
    logic early;
    do_reset();
    axis = 4'b0001;
    tick(10);
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
    vectors++;
    if (t16_obs !== 21'h0) begin
      miscompares++;
      $display("FAIL reset_mid got %h want %h", t16_obs, 21'h0);
    end
    early = 1'b0;
    for (int i = 0; i < 15; i++) begin
      tick(1);
      early = early | t16_block;
    end
    vectors++;
    if (early !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_mid_early got %b want %b", early, 1'b0);
    end
    tick(1);
    vectors++;
    if (t16_obs !== {1'b1, 1'b1, 3'd0, 16'd1}) begin
      miscompares++;
      $display("FAIL reset_mid_redetect got %h want %h", t16_obs, {1'b1, 1'b1, 3'd0, 16'd1});
    end
  endtask

  task automatic test_back_to_back();
    logic early;
    do_reset();
    axis = 4'b0001;
    tick(15);
    clear = 1'b1;
    tick(1);
    clear = 1'b0;
    vectors++;
    if (t16_obs !== 21'h0) begin
      miscompares++;
      $display("FAIL clear_beats_entry got %h want %h", t16_obs, 21'h0);
    end
    tick(1);
    vectors++;
    if (t16_obs !== {1'b0, 1'b1, 3'd0, 16'd0}) begin
      miscompares++;
      $display("FAIL clear_restart got %h want %h", t16_obs, {1'b0, 1'b1, 3'd0, 16'd0});
    end
    early = 1'b0;
    for (int i = 0; i < 14; i++) begin
      tick(1);
      early = early | t16_block;
    end
    tick(1);
    vectors++;
    if ({early, t16_block} !== 2'b01) begin
      miscompares++;
      $display("FAIL clear_redetect got %b want %b", {early, t16_block}, 2'b01);
    end
  endtask

  initial begin
    test_reset();
    test_legacy();
    test_priority();
    test_persist();
    test_sub_path();
    test_sticky();
    test_saturation();
    test_reset_mid();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule : tb_hls_deadlock_multi_monitor
`default_nettype wire

// File: doc/hls_deadlock_multi_monitor.md
Name: hls_deadlock_multi_monitor

Overview:
- Parametrised deadlock monitor for one HLS top-level instance, replacing the single-channel, single-cycle monitor generation.
- Watches N_AXIS AXI-Stream block flags and N_SUB sub-instance idle/block flags.
- Raises `block` only after the blocking condition has persisted for THRESH consecutive cycles.
- Reports the first offending source and blocked duration to the deadlock reporting logic; optional sticky mode with explicit clear.

Parameters:
- N_AXIS, 4, number of AXI-Stream channel block inputs (>=1)
- N_SUB, 2, number of sub-instance monitors (>=0; 0 disables the sub path)
- THRESH, 16, consecutive blocked cycles required before flagging (>=1; 1 equals legacy behaviour)
- STICKY, 0, 1: block holds until clear; 0: block follows the condition
- CYC_W, 16, width of the blocked-duration counter
- IDX_W, clog2(N_AXIS+1), width of the source index

Ports:
- clock  in  1  sole clock, rising edge
- reset  in  1  synchronous, active-high reset
- axis_block_sigs  in  N_AXIS  per-channel stream-blocked flag
- inst_idle_sigs  in  max(N_SUB,1)  per-sub-instance idle flag (ignored when N_SUB=0)
- inst_block_sigs  in  max(N_SUB,1)  per-sub-instance blocked flag (ignored when N_SUB=0)
- clear  in  1  single-cycle pulse: drop block and counters
- block  out  1  deadlock detected
- src_valid  out  1  src_idx holds a captured cause
- src_idx  out  IDX_W  0..N_AXIS-1 = stream channel; N_AXIS = sub-instance cause
- blocked_cycles  out  CYC_W  cycles spent with block=1, saturating

Behaviour:
Reset and clocking:
- Synchronous reset; all outputs, state and counters are 0 on the edge after reset=1. FSM resets to IDLE.
- Reset mid-operation aborts any state immediately.
- Priority order, highest first: reset, clear, normal operation.

Cause and persistence:
- Combinational cause: axis_any = OR(axis_block_sigs).
- sub_all = (N_SUB>0) AND (every i has inst_block[i] OR inst_idle[i]) AND OR(inst_block). So an all-idle set of sub-instances is not a deadlock.
- seq_block = axis_any OR sub_all.
- persist_cnt, width clog2(THRESH+1): +1 per cycle with seq_block=1, saturates at THRESH. Cleared to 0 on any cycle with seq_block=0.

FSM states and transitions:
- IDLE: block=0.
  - seq_block=1 and THRESH=1 -> BLOCKED.
  - seq_block=1 otherwise -> SUSPECT.
  - Both transitions capture the source.
- SUSPECT: block=0.
  - seq_block=0 -> IDLE; src_valid clears and src_idx -> 0.
  - persist_cnt+1 == THRESH with seq_block=1 -> BLOCKED.
- BLOCKED: block=1.
  - STICKY=0 and seq_block=0 -> IDLE; block falls on the next edge.
  - STICKY=1: stays until clear, even if seq_block=0.

Timing:
- If seq_block is first sampled high at edge k and stays high, block is high from edge k+THRESH-1 onward (i.e. visible in cycle k+THRESH).
- THRESH=1 gives one-register latency, identical to legacy.

Source capture:
- Happens only on the IDLE exit. src_idx = lowest-index asserted axis bit; if none, N_AXIS (sub cause). src_valid=1.
- The source is not updated while in SUSPECT or BLOCKED.

blocked_cycles:
- Cleared on entry to BLOCKED, so the entry cycle counts as 1.
- +1 per cycle in BLOCKED; saturates at 2^CYC_W-1, no wrap.
- Holds its value after returning to IDLE until the next BLOCKED entry, clear or reset.

clear:
- Next state IDLE; block, src_valid, src_idx, blocked_cycles and persist_cnt all go to 0.
- If seq_block is still 1 during the clear cycle, detection restarts on the following cycle. Clear wins over a simultaneous transition.

Decomposition:
- Shared package hls_deadlock_pkg: FSM state enum (IDLE, SUSPECT, BLOCKED), clog2 function, SUB_CAUSE index constant helper.
- One natural sub-module, hls_deadlock_persist_cnt: saturating persistence counter with clear and threshold-hit output.
- Cause reduction, FSM and capture stay in the top.

Test Plan:
- THRESH=1, STICKY=0: axis_block_sigs=4'b0001 at cycle 5 for 3 cycles -> block=1 in cycles 6-8 and 0 at cycle 9; src_idx=0; blocked_cycles=3.
- THRESH=16: axis bit 2 high for 15 cycles, then low 1 cycle, then high 20 cycles -> no block in the first burst. In the second burst block rises in its 16th cycle; src_idx=2; blocked_cycles=5 after the burst ends.
- Sub path: inst_idle=2'b01, inst_block=2'b10, axis=0 for THRESH cycles -> block=1, src_idx=4. With inst_idle=2'b11, inst_block=0 -> block stays 0.
- STICKY=1: block asserted, then all inputs go low -> block stays 1 and blocked_cycles keeps counting. clear pulse -> next cycle all outputs 0.
- Saturation: CYC_W=4, hold block for 40 cycles -> blocked_cycles holds at 15.
- Reset mid-SUSPECT (persist_cnt=10) and clear together with a BLOCKED entry -> all outputs 0; the reset case re-detects after the full THRESH.
